// File: rtl/sr_chain_pkg.sv
// Shared defaults for the 595-style serial chain receiver.
//   CHAIN_BITS  : default chain length (7 cascaded 8-bit registers)
//   REG_BITS    : bits per 595 register
//   SYNC_STAGES : default synchronizer depth per async input
//   cnt_width() : bit-counter width able to hold CHAIN_BITS+1
package sr_chain_pkg;

  localparam int unsigned REG_BITS    = 8;
  localparam int unsigned CHAIN_BITS  = 7 * REG_BITS;
  localparam int unsigned SYNC_STAGES = 2;

  function automatic int unsigned cnt_width(input int unsigned chain_bits);
    return $clog2(chain_bits + 2);
  endfunction

endpackage

// File: rtl/sr_chain_receiver_sync_edge.sv
// Multi-flop synchronizer with rising-edge pulse.
//   clk   : sampling clock
//   reset : synchronous active-high reset (all flops -> RESET_VAL)
//   d     : asynchronous input
//   q     : synchronized level (STAGES cycles late)
//   rise  : one-cycle pulse on a synchronized 0->1 transition
module sync_edge #(
  parameter int unsigned STAGES    = 2,
  parameter logic        RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q,
  output logic rise
);

  logic [STAGES-1:0] chain;
  logic              prev;

  always_ff @(posedge clk) begin
    if (reset) begin
      chain <= {STAGES{RESET_VAL}};
      prev  <= RESET_VAL;
    end else begin
      chain <= {chain[STAGES-2:0], d};
      prev  <= chain[STAGES-1];
    end
  end

  assign q    = chain[STAGES-1];
  assign rise = q & ~prev;

endmodule

// File: rtl/sr_chain_receiver.sv
// Cycle-accurate model of an N-bit cascaded 74HC595 chain, sampled in the
// master_clk domain.
//   master_clk  : system clock, all logic on rising edge
//   reset       : synchronous active-high reset
//   DS          : serial data (async)
//   SHCP        : shift clock (async), rising edge shifts
//   STCP        : storage clock (async), rising edge latches
//   MR_         : active-low shift-stage clear (async, level)
//   shift_q     : shift-stage contents
//   latch_q     : storage-stage contents
//   latch_valid : one-cycle pulse when latch_q updates
//   frame_ok    : last latch followed exactly CHAIN_BITS shifts
//   bit_count   : shifts since last latch/MR_, saturating at CHAIN_BITS+1
//   frame_count : number of latch events, wrapping
module sr_chain_receiver
  import sr_chain_pkg::*;
#(
  parameter int unsigned CHAIN_BITS      = sr_chain_pkg::CHAIN_BITS,
  parameter int unsigned CNT_WIDTH       = 7,
  parameter int unsigned SYNC_STAGES     = sr_chain_pkg::SYNC_STAGES,
  parameter int unsigned FRAME_CNT_WIDTH = 16
) (
  input  logic                       master_clk,
  input  logic                       reset,
  input  logic                       DS,
  input  logic                       SHCP,
  input  logic                       STCP,
  input  logic                       MR_,
  output logic [CHAIN_BITS-1:0]      shift_q,
  output logic [CHAIN_BITS-1:0]      latch_q,
  output logic                       latch_valid,
  output logic                       frame_ok,
  output logic [CNT_WIDTH-1:0]       bit_count,
  output logic [FRAME_CNT_WIDTH-1:0] frame_count
);

  localparam logic [CNT_WIDTH-1:0] CNT_FULL = CNT_WIDTH'(CHAIN_BITS);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = CNT_WIDTH'(CHAIN_BITS + 1);

  logic ds_sync, mr_sync;
  logic shift, latch;
  logic shcp_sync_unused, stcp_sync_unused;
  logic ds_rise_unused, mr_rise_unused;
  logic [CNT_WIDTH-1:0] cnt_base, cnt_next;

  // All four inputs use the same depth so DS stays aligned with SHCP.
  sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_ds (
    .clk(master_clk), .reset(reset), .d(DS), .q(ds_sync), .rise(ds_rise_unused)
  );
  sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_shcp (
    .clk(master_clk), .reset(reset), .d(SHCP), .q(shcp_sync_unused), .rise(shift)
  );
  sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_stcp (
    .clk(master_clk), .reset(reset), .d(STCP), .q(stcp_sync_unused), .rise(latch)
  );
  sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_mr (
    .clk(master_clk), .reset(reset), .d(MR_), .q(mr_sync), .rise(mr_rise_unused)
  );

  // A latch restarts the count; a shift in the same cycle then counts as 1.
  always_comb begin
    cnt_base = latch ? '0 : bit_count;
    cnt_next = cnt_base;
    if (shift && (cnt_base != CNT_MAX))
      cnt_next = cnt_base + CNT_WIDTH'(1);
  end

  always_ff @(posedge master_clk) begin
    if (reset) begin
      shift_q     <= '0;
      latch_q     <= '0;
      latch_valid <= 1'b0;
      frame_ok    <= 1'b0;
      bit_count   <= '0;
      frame_count <= '0;
    end else begin
      latch_valid <= latch;
      // Storage stage always captures the pre-shift / pre-clear value.
      if (latch) begin
        latch_q     <= shift_q;
        frame_ok    <= (bit_count == CNT_FULL);
        frame_count <= frame_count + FRAME_CNT_WIDTH'(1);
      end
      if (!mr_sync) begin
        shift_q   <= '0;
        bit_count <= '0;
      end else begin
        if (shift)
          shift_q <= {shift_q[CHAIN_BITS-2:0], ds_sync};
        bit_count <= cnt_next;
      end
    end
  end

endmodule

// File: tb/tb_sr_chain_receiver.sv
module tb_sr_chain_receiver;

  localparam int unsigned CB  = 56;
  localparam int unsigned CW  = 7;
  localparam int unsigned FCW = 16;

  logic           master_clk = 1'b0;
  logic           reset = 1'b1;
  logic           DS = 1'b0, SHCP = 1'b0, STCP = 1'b0, MR_ = 1'b1;
  logic [CB-1:0]  shift_q, latch_q;
  logic           latch_valid, frame_ok;
  logic [CW-1:0]  bit_count;
  logic [FCW-1:0] frame_count;

  int unsigned errors = 0;
  int unsigned checks = 0;

  sr_chain_receiver #(
    .CHAIN_BITS(CB), .CNT_WIDTH(CW), .SYNC_STAGES(2), .FRAME_CNT_WIDTH(FCW)
  ) dut (
    .master_clk(master_clk), .reset(reset), .DS(DS), .SHCP(SHCP), .STCP(STCP),
    .MR_(MR_), .shift_q(shift_q), .latch_q(latch_q), .latch_valid(latch_valid),
    .frame_ok(frame_ok), .bit_count(bit_count), .frame_count(frame_count)
  );

  always #5 master_clk = ~master_clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int unsigned n);
    repeat (n) @(posedge master_clk);
    #1;
  endtask

  task automatic shift_bit(input logic b);
    DS = b; SHCP = 1'b0; tick(4);
    SHCP = 1'b1; tick(4);
    SHCP = 1'b0;
  endtask

  task automatic shift_word(input logic [CB-1:0] v, input int unsigned nbits);
    logic [CB-1:0] t;
    t = v;
    for (int i = int'(nbits) - 1; i >= 0; i--) shift_bit(t[i]);
  endtask

  // Latch and count latch_valid cycles across the whole STCP pulse.
  task automatic do_latch(output int unsigned pulses);
    pulses = 0;
    STCP = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      if (latch_valid) pulses++;
    end
    STCP = 1'b0; tick(4);
  endtask

  task automatic mr_clear();
    MR_ = 1'b0; tick(10);
    chk("mr_shift_q", 64'(shift_q), 64'd0);
    chk("mr_bit_count", 64'(bit_count), 64'd0);
    MR_ = 1'b1; tick(4);
  endtask

  int unsigned p;
  logic [CB-1:0] lq_before;

  initial begin
    tick(3);
    reset = 1'b0;
    chk("rst_shift_q", 64'(shift_q), 64'd0);
    chk("rst_latch_q", 64'(latch_q), 64'd0);
    chk("rst_valid", 64'(latch_valid), 64'd0);
    chk("rst_frame_ok", 64'(frame_ok), 64'd0);
    chk("rst_bit_count", 64'(bit_count), 64'd0);
    chk("rst_frame_count", 64'(frame_count), 64'd0);

    // 1: full frame
    shift_word(56'hA5_00FF_1234_5678, 56);
    chk("t1_shift_q", 64'(shift_q), 64'h00A5_00FF_1234_5678);
    chk("t1_bit_count", 64'(bit_count), 64'd56);
    do_latch(p);
    chk("t1_latch_q", 64'(latch_q), 64'h00A5_00FF_1234_5678);
    chk("t1_valid_pulses", 64'(p), 64'd1);
    chk("t1_frame_ok", 64'(frame_ok), 64'd1);
    chk("t1_frame_count", 64'(frame_count), 64'd1);
    chk("t1_valid_low", 64'(latch_valid), 64'd0);

    // 2: short frame
    mr_clear();
    chk("t2_latch_kept", 64'(latch_q), 64'h00A5_00FF_1234_5678);
    shift_word(56'hC3, 8);
    do_latch(p);
    chk("t2_latch_q", 64'(latch_q), 64'hC3);
    chk("t2_frame_ok", 64'(frame_ok), 64'd0);
    chk("t2_bit_count", 64'(bit_count), 64'd0);
    chk("t2_frame_count", 64'(frame_count), 64'd2);

    // 3: over-long frame saturates the counter
    for (int i = 0; i < 60; i++) shift_bit(1'b1);
    chk("t3_bit_count_sat", 64'(bit_count), 64'd57);
    do_latch(p);
    chk("t3_frame_ok", 64'(frame_ok), 64'd0);
    chk("t3_latch_q", 64'(latch_q), 64'h00FF_FFFF_FFFF_FFFF);
    chk("t3_frame_count", 64'(frame_count), 64'd3);

    // 4: partial frame discarded by MR_
    for (int i = 0; i < 20; i++) shift_bit(1'b1);
    chk("t4_bit_count_20", 64'(bit_count), 64'd20);
    mr_clear();
    shift_word(56'h55_5555_5555_5555, 56);
    do_latch(p);
    chk("t4_frame_ok", 64'(frame_ok), 64'd1);
    chk("t4_latch_q", 64'(latch_q), 64'h0055_5555_5555_5555);

    // 5: SHCP and STCP rising together
    mr_clear();
    for (int i = 0; i < 55; i++) shift_bit(1'b1);
    DS = 1'b0; SHCP = 1'b0; STCP = 1'b0; tick(4);
    SHCP = 1'b1; STCP = 1'b1; tick(4);
    SHCP = 1'b0; STCP = 1'b0; tick(4);
    chk("t5_latch_q", 64'(latch_q), 64'h007F_FFFF_FFFF_FFFF);
    chk("t5_shift_q", 64'(shift_q), 64'h00FF_FFFF_FFFF_FFFE);
    chk("t5_frame_ok", 64'(frame_ok), 64'd0);
    chk("t5_bit_count", 64'(bit_count), 64'd1);
    chk("t5_frame_count", 64'(frame_count), 64'd5);

    // 6: reset while an SHCP edge is still in the synchronizer
    DS = 1'b1; SHCP = 1'b1; tick(1);
    reset = 1'b1; SHCP = 1'b0; tick(1);
    reset = 1'b0; tick(2);
    chk("t6_shift_q", 64'(shift_q), 64'd0);
    chk("t6_latch_q", 64'(latch_q), 64'd0);
    chk("t6_bit_count", 64'(bit_count), 64'd0);
    chk("t6_frame_count", 64'(frame_count), 64'd0);
    chk("t6_frame_ok", 64'(frame_ok), 64'd0);
    tick(4);
    chk("t6_no_late_shift", 64'(bit_count), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
